// File: rtl/pool_1.sv
// pool_1: 2x2 stride-2 signed max-pooling engine.
// Reads each conv-1 feature map from BRAM and writes the max-pooled map back
// out one pooled element at a time.
module pool_1 #(
    parameter int DATA_SIZE         = 8,
    parameter int CONV1_DEEP        = 20,
    parameter int CONV1_OUTPUT      = 24,
    parameter int POOL1_SIZE        = 2,
    parameter int POOL1_OUTPUT      = 12,
    parameter int conv1_result_base = 0,
    parameter int pool1_result_base = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pool_1_en,
    input  logic [DATA_SIZE-1:0] conv_result_bram_douta,
    output logic                 conv_result_bram_ena,
    output logic [14:0]          conv_result_bram_addra,
    output logic                 pool_result_bram_ena,
    output logic                 pool_result_bram_wea,
    output logic [11:0]          pool_result_bram_addra,
    output logic [DATA_SIZE-1:0] pool_result_bram_dina,
    output logic                 pool_1_finish
);

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        CHECK = 5'b00010,
        LOAD  = 5'b00100,
        STORE = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    localparam logic [14:0] RD_BASE  = 15'(conv1_result_base);
    localparam logic [11:0] WR_BASE  = 12'(pool1_result_base);
    localparam logic [14:0] MAP_SIDE = 15'(CONV1_OUTPUT);
    localparam logic [14:0] MAP_AREA = 15'(CONV1_OUTPUT * CONV1_OUTPUT);
    localparam logic [14:0] WIN_SIDE = 15'(POOL1_SIZE);
    localparam logic [11:0] OUT_SIDE = 12'(POOL1_OUTPUT);
    localparam logic [11:0] OUT_AREA = 12'(POOL1_OUTPUT * POOL1_OUTPUT);
    localparam logic [3:0]  POS_LAST = 4'(POOL1_OUTPUT - 1);
    localparam logic [4:0]  F_END    = 5'(CONV1_DEEP);

    state_t               state;
    logic [4:0]           f;
    logic [3:0]           pr;
    logic [3:0]           pc;
    logic [1:0]           slot;
    logic [1:0]           cyc;
    logic [DATA_SIZE-1:0] max_val;

    logic [14:0]          rd_row;
    logic [14:0]          rd_col;
    logic [14:0]          rd_addr;
    logic [11:0]          wr_addr;

    // Address of the window element selected by slot (bit 1 = row offset, bit 0 = column offset) and of the pooled output.
    always_comb begin
        rd_row  = 15'(pr) * WIN_SIDE + 15'(slot[1]);
        rd_col  = 15'(pc) * WIN_SIDE + 15'(slot[0]);
        rd_addr = RD_BASE + 15'(f) * MAP_AREA + rd_row * MAP_SIDE + rd_col;
        wr_addr = WR_BASE + 12'(f) * OUT_AREA + 12'(pr) * OUT_SIDE + 12'(pc);
    end

    // Sequencer: check, four 4-cycle reads into the running max, one store; enable low freezes everything except the DONE exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            f                      <= '0;
            pr                     <= '0;
            pc                     <= '0;
            slot                   <= '0;
            cyc                    <= '0;
            max_val                <= '0;
            conv_result_bram_ena   <= 1'b0;
            conv_result_bram_addra <= '0;
            pool_result_bram_ena   <= 1'b0;
            pool_result_bram_wea   <= 1'b0;
            pool_result_bram_addra <= '0;
            pool_result_bram_dina  <= '0;
            pool_1_finish          <= 1'b0;
        end else if (state == DONE && !pool_1_en) begin
            state <= IDLE;
        end else if (pool_1_en) begin
            case (state)
                IDLE: begin
                    f                    <= '0;
                    pr                   <= '0;
                    pc                   <= '0;
                    slot                 <= '0;
                    cyc                  <= '0;
                    pool_1_finish        <= 1'b0;
                    conv_result_bram_ena <= 1'b0;
                    pool_result_bram_ena <= 1'b0;
                    pool_result_bram_wea <= 1'b0;
                    state                <= CHECK;
                end
                CHECK: begin
                    pool_result_bram_ena <= 1'b0;
                    pool_result_bram_wea <= 1'b0;
                    if (f == F_END) begin
                        state <= DONE;
                    end else begin
                        slot  <= '0;
                        cyc   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (cyc == 2'd0) begin
                        conv_result_bram_ena   <= 1'b1;
                        conv_result_bram_addra <= rd_addr;
                    end
                    if (cyc == 2'd3) begin
                        if (slot == 2'd0) begin
                            max_val <= conv_result_bram_douta;
                        end else if ($signed(conv_result_bram_douta) > $signed(max_val)) begin
                            max_val <= conv_result_bram_douta;
                        end
                        slot <= slot + 2'd1;
                        if (slot == 2'd3) begin
                            conv_result_bram_ena <= 1'b0;
                            state                <= STORE;
                        end
                    end
                    cyc <= cyc + 2'd1;
                end
                STORE: begin
                    pool_result_bram_ena   <= 1'b1;
                    pool_result_bram_wea   <= 1'b1;
                    pool_result_bram_addra <= wr_addr;
                    pool_result_bram_dina  <= max_val;
                    if (pc == POS_LAST) begin
                        pc <= '0;
                        if (pr == POS_LAST) begin
                            pr <= '0;
                            f  <= f + 5'd1;
                        end else begin
                            pr <= pr + 4'd1;
                        end
                    end else begin
                        pc <= pc + 4'd1;
                    end
                    state <= CHECK;
                end
                DONE: begin
                    pool_1_finish        <= 1'b1;
                    conv_result_bram_ena <= 1'b0;
                    pool_result_bram_ena <= 1'b0;
                    pool_result_bram_wea <= 1'b0;
                end
                default: begin
                    conv_result_bram_ena <= 1'b0;
                    pool_result_bram_ena <= 1'b0;
                    pool_result_bram_wea <= 1'b0;
                    state                <= IDLE;
                end
            endcase
        end
    end

endmodule
